alu_mc: RTL

- Multi-cycle 8-bit execute stage directly downstream of the register file.
- Consumes the two read values (rs, rt) plus a decoded op.
- Computes single-cycle ALU ops, iterative shifts and an iterative 8-cycle shift-add multiply.
- Returns an 8-bit result with a one-cycle write-enable pulse that drives the register file write port. The destination address is handled by the decoder.

---
 rtl/alu_mc.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle 8-bit execute stage: single-cycle ALU ops, iterative shifts and
// an 8-iteration shift-add multiply, with a one-cycle register-file write pulse.
module alu_mc #(
    parameter int DW      = 8,
    parameter int MUL_CYC = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [2:0]    op_i,
    input  logic [DW-1:0] rs_val_i,
    input  logic [DW-1:0] rt_val_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          wen_o,
    output logic [DW-1:0] result_o,
    output logic          carry_o,
    output logic          zero_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [2*DW-1:0] acc_q, acc_d;    // shift register / multiplicand
    logic [DW-1:0]   mplr_q, mplr_d;
    logic [2*DW-1:0] prod_q, prod_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [DW-1:0]   result_q, result_d;
    logic            carry_q, carry_d;
    logic            zero_q, zero_d;

    logic            commit;
    logic [DW-1:0]   commit_res;
    logic            commit_c;
    logic [DW:0]     sum;
    logic [2*DW-1:0] prod_nxt;
    logic [DW-1:0]   sh_val;
    logic            sh_bit;
    logic [2:0]      amt;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        mplr_d     = mplr_q;
        prod_d     = prod_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        commit     = 1'b0;
        commit_res = '0;
        commit_c   = 1'b0;
        sum        = '0;
        prod_nxt   = '0;
        sh_val     = '0;
        sh_bit     = 1'b0;
        amt        = rt_val_i[2:0];

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d = op_i;
                    case (op_i)
                        OP_ADD: begin
                            sum        = {1'b0, rs_val_i} + {1'b0, rt_val_i};
                            commit     = 1'b1;
                            commit_res = sum[DW-1:0];
                            commit_c   = sum[DW];
                        end
                        OP_SUB: begin
                            // carry out of rs + ~rt + 1 is the "no borrow" flag
                            sum        = {1'b0, rs_val_i} + {1'b0, ~rt_val_i} + 9'd1;
                            commit     = 1'b1;
                            commit_res = sum[DW-1:0];
                            commit_c   = sum[DW];
                        end
                        OP_AND: begin
                            commit     = 1'b1;
                            commit_res = rs_val_i & rt_val_i;
                        end
                        OP_XOR: begin
                            commit     = 1'b1;
                            commit_res = rs_val_i ^ rt_val_i;
                        end
                        OP_MOV: begin
                            commit     = 1'b1;
                            commit_res = rt_val_i;
                        end
                        OP_SLL, OP_SRL: begin
                            if (amt == 3'd0) begin
                                commit     = 1'b1;
                                commit_res = rs_val_i;
                            end else begin
                                acc_d   = {{DW{1'b0}}, rs_val_i};
                                cnt_d   = {1'b0, amt};
                                state_d = S_RUN;
                            end
                        end
                        default: begin  // OP_MUL
                            acc_d   = {{DW{1'b0}}, rs_val_i};
                            mplr_d  = rt_val_i;
                            prod_d  = '0;
                            cnt_d   = 4'(MUL_CYC);
                            state_d = S_RUN;
                        end
                    endcase
                end
            end

            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (op_q == OP_MUL) begin
                    prod_nxt = prod_q + (mplr_q[0] ? acc_q : '0);
                    prod_d   = prod_nxt;
                    acc_d    = acc_q << 1;
                    mplr_d   = mplr_q >> 1;
                    if (cnt_q == 4'd1) begin
                        commit     = 1'b1;
                        commit_res = prod_nxt[DW-1:0];
                        commit_c   = |prod_nxt[2*DW-1:DW];
                    end
                end else begin
                    if (op_q == OP_SLL) begin
                        sh_val = {acc_q[DW-2:0], 1'b0};
                        sh_bit = acc_q[DW-1];
                    end else begin
                        sh_val = {1'b0, acc_q[DW-1:1]};
                        sh_bit = acc_q[0];
                    end
                    acc_d = {{DW{1'b0}}, sh_val};
                    // only the bit shifted out on the final step survives as carry
                    if (cnt_q == 4'd1) begin
                        commit     = 1'b1;
                        commit_res = sh_val;
                        commit_c   = sh_bit;
                    end
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            result_d = commit_res;
            carry_d  = commit_c;
            zero_d   = (commit_res == '0);
            state_d  = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            mplr_q   <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mplr_q   <= mplr_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign wen_o    = (state_q == S_DONE);
    assign result_o = result_q;
    assign carry_o  = carry_q;
    assign zero_o   = zero_q;

endmodule
